// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared counter width, board divisor constants and divisor type for clk_div_multi
package clk_div_pkg;

  localparam int CNT_W_DEF = 32;

  // Half-period is DIV+1 cycles of the 50 MHz system clock.
  localparam int DIV_DOT_MATRIX = 2500;
  localparam int DIV_SEG_SCAN   = 24_999;      // 1 kHz
  localparam int DIV_DEBOUNCE   = 249_999;     // 100 Hz
  localparam int DIV_1HZ        = 24_999_999;

  typedef logic [CNT_W_DEF-1:0] div_t;

endpackage

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divider channel with shadowed divisor applied at period boundaries
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DIV_DOT_MATRIX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             clk_out,
  output logic             tick,
  output logic             pend
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_act;
  logic [CNT_W-1:0] div_shd;
  logic             wrap;
  logic             restart;
  logic             apply;

  always_comb begin
    wrap    = en && (cnt == div_act);
    restart = en && sync;
    apply   = pend && (!en || restart || wrap);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      pend    <= 1'b0;
      div_act <= CNT_W'(DEFAULT_DIV);
      div_shd <= CNT_W'(DEFAULT_DIV);
    end else begin
      if (!en || restart) begin
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end else if (wrap) begin
        cnt     <= '0;
        clk_out <= ~clk_out;
        tick    <= 1'b1;
      end else begin
        cnt  <= cnt + CNT_W'(1);
        tick <= 1'b0;
      end
      // A write on the applying edge consumes the old shadow and re-arms pend.
      if (apply) begin
        div_act <= div_shd;
        pend    <= 1'b0;
      end
      if (wr) begin
        div_shd <= wr_div;
        pend    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - NUM_CH reprogrammable clock dividers; CLK_DIV_SYNC_EN adds a phase-align sync input
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int  NUM_CH      = 4,
  parameter int  CNT_W       = CNT_W_DEF,
  parameter int  DEFAULT_DIV = DIV_DOT_MATRIX,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
`ifdef CLK_DIV_SYNC_EN
  input  logic              sync,
`endif
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pend
);

  logic sync_all;

`ifdef CLK_DIV_SYNC_EN
  assign sync_all = sync;
`else
  assign sync_all = 1'b0;
`endif

  // Channel indices >= NUM_CH match no decoder, so such writes fall away.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_chan #(
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .en     (en[i]),
      .sync   (sync_all),
      .wr     (wr_en && (wr_ch == CH_W'(i))),
      .wr_div (wr_div),
      .clk_out(clk_out[i]),
      .tick   (tick[i]),
      .pend   (pend[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - self-checking bench for clk_div_multi
`timescale 1ns/1ps
module tb_clk_div_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, wr_en, wr_ch;
  logic [1:0] en;
  logic [7:0] wr_div;
  logic [1:0] clk_out, tick, pend;

  logic       rst3, wr_en3;
  logic [2:0] en3;
  logic [1:0] wr_ch3;
  logic [7:0] wr_div3;
  logic [2:0] clk_out3, tick3, pend3;

`ifdef CLK_DIV_SYNC_EN
  logic sync, sync3, sync_req;
`endif

  clk_div_multi #(.NUM_CH(2), .CNT_W(8), .DEFAULT_DIV(3)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .wr_en  (wr_en),
    .wr_ch  (wr_ch),
    .wr_div (wr_div),
`ifdef CLK_DIV_SYNC_EN
    .sync   (sync),
`endif
    .clk_out(clk_out),
    .tick   (tick),
    .pend   (pend)
  );

  clk_div_multi #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(3)) u_dut3 (
    .clk    (clk),
    .rst    (rst3),
    .en     (en3),
    .wr_en  (wr_en3),
    .wr_ch  (wr_ch3),
    .wr_div (wr_div3),
`ifdef CLK_DIV_SYNC_EN
    .sync   (sync3),
`endif
    .clk_out(clk_out3),
    .tick   (tick3),
    .pend   (pend3)
  );

  typedef struct {
    logic [8:0] ex;
    logic [8:0] mask;
    logic       sel;
    int         sec;
    int         idx;
  } chk_t;

  typedef struct packed {
    logic       rst;
    logic [1:0] en;
    logic       wr_en;
    logic       wr_ch;
    logic [7:0] wr_div;
    logic [1:0] co;
    logic [1:0] tk;
    logic [1:0] pd;
  } vec_t;

  chk_t       sb[$];
  vec_t       tbl[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  chk_t       cur;
  logic [8:0] act;
  logic       co0, co1, co2, tk0, tk1, tk2, pd0, pd2;

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      act = cur.sel ? {clk_out3, tick3, pend3} : {3'b000, clk_out, tick, pend};
      n_checks++;
      if ((act & cur.mask) !== (cur.ex & cur.mask)) begin
        n_fail++;
        $display("FAIL sec%0d/step%0d {clk_out,tick,pend}: got %b required %b",
                 cur.sec, cur.idx, act & cur.mask, cur.ex & cur.mask);
      end
    end
  end

  function automatic vec_t v(input logic r, input logic [1:0] e, input logic we, input logic wc,
                             input logic [7:0] wd, input logic [1:0] co, input logic [1:0] tk,
                             input logic [1:0] pd);
    return '{rst: r, en: e, wr_en: we, wr_ch: wc, wr_div: wd, co: co, tk: tk, pd: pd};
  endfunction

  task automatic drive(input logic r, input logic [1:0] e, input logic we, input logic wc,
                       input logic [7:0] wd, input logic [5:0] ex, input int sec, input int idx);
    @(negedge clk);
    rst = r; en = e; wr_en = we; wr_ch = wc; wr_div = wd;
`ifdef CLK_DIV_SYNC_EN
    sync = sync_req;
`endif
    sb.push_back('{ex: {3'b000, ex}, mask: 9'h03F, sel: 1'b0, sec: sec, idx: idx});
  endtask

  task automatic drive3(input logic r, input logic [2:0] e, input logic we, input logic [1:0] wc,
                        input logic [7:0] wd, input logic [8:0] ex, input int idx);
    @(negedge clk);
    rst3 = r; en3 = e; wr_en3 = we; wr_ch3 = wc; wr_div3 = wd;
    sb.push_back('{ex: ex, mask: 9'h1FF, sel: 1'b1, sec: 3, idx: idx});
  endtask

  initial begin
    rst = 1'b1; en = '0; wr_en = 1'b0; wr_ch = 1'b0; wr_div = '0;
    rst3 = 1'b1; en3 = '0; wr_en3 = 1'b0; wr_ch3 = '0; wr_div3 = '0;
`ifdef CLK_DIV_SYNC_EN
    sync = 1'b0; sync3 = 1'b0; sync_req = 1'b0;
`endif

    // Reset, start-up, mid-period write to ch1, div=0 on ch0, reset mid-period, write to disabled ch1.
    for (int i = 0; i < 3; i++) tbl.push_back(v(1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    for (int i = 0; i < 3; i++) tbl.push_back(v(0, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    tbl.push_back(v(0, 2'b11, 0, 0, 0, 2'b11, 2'b11, 2'b00));
    for (int i = 0; i < 3; i++) tbl.push_back(v(0, 2'b11, 0, 0, 0, 2'b11, 2'b00, 2'b00));
    tbl.push_back(v(0, 2'b11, 0, 0, 0, 2'b00, 2'b11, 2'b00));
    tbl.push_back(v(0, 2'b11, 1, 1, 1, 2'b00, 2'b00, 2'b10));
    tbl.push_back(v(0, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b10));
    tbl.push_back(v(0, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b10));
    tbl.push_back(v(0, 2'b11, 0, 0, 0, 2'b11, 2'b11, 2'b00));
    tbl.push_back(v(0, 2'b11, 0, 0, 0, 2'b11, 2'b00, 2'b00));
    tbl.push_back(v(0, 2'b11, 0, 0, 0, 2'b01, 2'b10, 2'b00));
    tbl.push_back(v(0, 2'b11, 0, 0, 0, 2'b01, 2'b00, 2'b00));
    tbl.push_back(v(0, 2'b11, 0, 0, 0, 2'b10, 2'b11, 2'b00));
    tbl.push_back(v(0, 2'b11, 0, 0, 0, 2'b10, 2'b00, 2'b00));
    tbl.push_back(v(0, 2'b11, 0, 0, 0, 2'b00, 2'b10, 2'b00));
    tbl.push_back(v(0, 2'b11, 1, 0, 0, 2'b00, 2'b00, 2'b01));
    tbl.push_back(v(0, 2'b11, 0, 0, 0, 2'b11, 2'b11, 2'b00));
    tbl.push_back(v(0, 2'b11, 0, 0, 0, 2'b10, 2'b01, 2'b00));
    tbl.push_back(v(0, 2'b11, 0, 0, 0, 2'b01, 2'b11, 2'b00));
    tbl.push_back(v(0, 2'b11, 0, 0, 0, 2'b00, 2'b01, 2'b00));
    tbl.push_back(v(0, 2'b11, 0, 0, 0, 2'b11, 2'b11, 2'b00));
    tbl.push_back(v(0, 2'b11, 0, 0, 0, 2'b10, 2'b01, 2'b00));
    tbl.push_back(v(1, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    tbl.push_back(v(0, 2'b11, 1, 1, 1, 2'b00, 2'b00, 2'b10));
    tbl.push_back(v(0, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b10));
    tbl.push_back(v(1, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    for (int i = 0; i < 3; i++) tbl.push_back(v(0, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    tbl.push_back(v(0, 2'b11, 0, 0, 0, 2'b11, 2'b11, 2'b00));
    for (int i = 0; i < 3; i++) tbl.push_back(v(0, 2'b11, 0, 0, 0, 2'b11, 2'b00, 2'b00));
    tbl.push_back(v(0, 2'b11, 0, 0, 0, 2'b00, 2'b11, 2'b00));
    tbl.push_back(v(0, 2'b01, 1, 1, 1, 2'b00, 2'b00, 2'b10));
    tbl.push_back(v(0, 2'b01, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    tbl.push_back(v(0, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b00));
    tbl.push_back(v(0, 2'b11, 0, 0, 0, 2'b11, 2'b11, 2'b00));
    tbl.push_back(v(0, 2'b11, 0, 0, 0, 2'b11, 2'b00, 2'b00));
    tbl.push_back(v(0, 2'b11, 0, 0, 0, 2'b01, 2'b10, 2'b00));

    for (int i = 0; i < tbl.size(); i++)
      drive(tbl[i].rst, tbl[i].en, tbl[i].wr_en, tbl[i].wr_ch, tbl[i].wr_div,
            {tbl[i].co, tbl[i].tk, tbl[i].pd}, 1, i);

    // Write of 5 to ch0 landing on its wrap edge (k=8): next half-period still 4, then 6.
    drive(1, 2'b00, 0, 0, 0, 6'b0, 2, 0);
    co0 = 1'b0; co1 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tk0 = (k == 4) || (k == 8) || (k == 12) || (k == 18);
      tk1 = (k % 4) == 0;
      pd0 = (k >= 8) && (k < 12);
      if (tk0) co0 = ~co0;
      if (tk1) co1 = ~co1;
      drive(0, 2'b11, k == 8, 0, 8'd5, {co1, co0, tk1, tk0, 1'b0, pd0}, 2, k);
    end

    // Out-of-range channel write, then back-to-back writes to ch2 (last one wins).
    drive3(1, 3'b000, 0, 2'd0, 8'd0, 9'b0, 0);
    co0 = 1'b0; co1 = 1'b0; co2 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tk0 = (k % 4) == 0;
      tk2 = (k == 4) || (k == 8) || (k == 10) || (k == 12);
      pd2 = (k >= 5) && (k < 8);
      if (tk0) begin co0 = ~co0; co1 = ~co1; end
      if (tk2) co2 = ~co2;
      drive3(0, 3'b111, (k == 2) || (k == 5) || (k == 6), (k == 2) ? 2'd3 : 2'd2,
             (k == 2) ? 8'd9 : ((k == 5) ? 8'd5 : 8'd1),
             {co2, co1, co0, tk2, tk0, tk0, pd2, 2'b00}, k);
    end

`ifdef CLK_DIV_SYNC_EN
    // ch1 started two cycles late; sync at k=9 realigns both and applies ch1's pending divisor.
    drive(1, 2'b00, 0, 0, 0, 6'b0, 4, 0);
    co0 = 1'b0; co1 = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      tk0 = (k == 4) || (k == 8) || (k == 13) || (k == 17);
      tk1 = (k == 6) || (k == 13) || (k == 17);
      if (tk0) co0 = ~co0;
      if (tk1) co1 = ~co1;
      if (k == 9) begin co0 = 1'b0; co1 = 1'b0; end
      sync_req = (k == 9);
      drive(0, (k < 3) ? 2'b01 : 2'b11, k == 7, 1, 8'd3,
            {co1, co0, tk1, tk0, (k == 7) || (k == 8), 1'b0}, 4, k);
    end
    sync_req = 1'b0;
`endif

    @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d checks still queued, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
